riscv_lsu: RTL and testbench

//  Load/store unit in the MEM stage; consumes the decoder's MemWr/MemtoReg/MemOp controls.

---
 rtl/riscv_lsu_pkg.sv | 35 +++
 rtl/riscv_lsu_align.sv | 53 +++++
 rtl/riscv_lsu.sv | 125 ++++++++++++
 tb/tb_riscv_lsu.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_lsu_pkg.sv
// Shared MemOp codes, LSU state encoding and the latched-request record.
package riscv_lsu_pkg;

    localparam int NUM_LANES = 4;

    localparam logic [2:0] MEMOP_B    = 3'b000;
    localparam logic [2:0] MEMOP_H    = 3'b001;
    localparam logic [2:0] MEMOP_W    = 3'b010;
    localparam logic [2:0] MEMOP_BU   = 3'b100;
    localparam logic [2:0] MEMOP_HU   = 3'b101;
    localparam logic [2:0] MEMOP_NONE = 3'b111;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_REQ  = 2'd1,
        LSU_WAIT = 2'd2,
        LSU_DONE = 2'd3
    } lsu_state_e;

    // What the load path needs to remember once the bus transaction is launched
    typedef struct packed {
        logic       we;
        logic [2:0] op;
        logic [1:0] off;
    } lsu_req_t;

    function automatic logic is_aligned(input logic [2:0] op, input logic [1:0] off);
        case (op)
            MEMOP_B, MEMOP_BU: is_aligned = 1'b1;
            MEMOP_H, MEMOP_HU: is_aligned = ~off[0];
            default:           is_aligned = (off == 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/riscv_lsu_align.sv
// Byte-lane steering: store enables/replication and load select/extend.
module riscv_lsu_align
    import riscv_lsu_pkg::*;
(
    input  logic [2:0]  st_op,
    input  logic [1:0]  st_off,
    input  logic [31:0] wdata,
    output logic [3:0]  st_be,
    output logic [31:0] st_wdata,
    input  logic [2:0]  ld_op,
    input  logic [1:0]  ld_off,
    input  logic [31:0] rdata,
    output logic [31:0] ld_data
);

    logic [NUM_LANES-1:0][7:0] lanes;
    logic [7:0]                ld_byte;
    logic [15:0]               ld_half;

    assign lanes   = rdata;
    assign ld_byte = lanes[ld_off];
    assign ld_half = ld_off[1] ? rdata[31:16] : rdata[15:0];

    // Store side: enable the addressed lanes and replicate data across them
    always_comb begin
        st_be    = 4'b1111;
        st_wdata = wdata;
        case (st_op)
            MEMOP_B, MEMOP_BU: begin
                st_be    = 4'b0001 << st_off;
                st_wdata = {4{wdata[7:0]}};
            end
            MEMOP_H, MEMOP_HU: begin
                st_be    = st_off[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{wdata[15:0]}};
            end
            default: ;
        endcase
    end

    // Load side: pick the addressed byte/half and extend it
    always_comb begin
        ld_data = rdata;
        case (ld_op)
            MEMOP_B:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            MEMOP_BU: ld_data = {24'd0, ld_byte};
            MEMOP_H:  ld_data = {{16{ld_half[15]}}, ld_half};
            MEMOP_HU: ld_data = {16'd0, ld_half};
            default: ;
        endcase
    end

endmodule

// File: rtl/riscv_lsu.sv
// MEM-stage load/store unit: one req/gnt/rvalid bus access per load/store,
// pipeline stall while it is in flight, misalign and timeout reporting.
module riscv_lsu
    import riscv_lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_i,
    input  logic        MemWr_i,
    input  logic        MemtoReg_i,
    input  logic [2:0]  MemOp_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        stall_o,
    output logic        done_o,
    output logic [31:0] rdata_o,
    output logic        misalign_o,
    output logic        bus_err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

    lsu_state_e        state;
    lsu_req_t          req_q;
    logic [CNT_W-1:0]  cnt;
    logic              access, candidate, aligned, start, timeout;
    logic [3:0]        st_be;
    logic [31:0]       st_wdata, ld_data;

    // Gated by rst so nothing asserts combinationally while the unit is held in reset
    assign access    = MemWr_i | MemtoReg_i;
    assign candidate = ~rst & (state == LSU_IDLE) & req_valid_i & access & (MemOp_i != MEMOP_NONE);
    assign aligned   = is_aligned(MemOp_i, addr_i[1:0]);
    assign start     = candidate & aligned;
    assign timeout   = (cnt == CNT_MAX);

    assign misalign_o = candidate & ~aligned;
    assign stall_o    = start | (state == LSU_REQ) | (state == LSU_WAIT);

    riscv_lsu_align u_align (
        .st_op    (MemOp_i),
        .st_off   (addr_i[1:0]),
        .wdata    (wdata_i),
        .st_be    (st_be),
        .st_wdata (st_wdata),
        .ld_op    (req_q.op),
        .ld_off   (req_q.off),
        .rdata    (mem_rdata_i),
        .ld_data  (ld_data)
    );

    // Access FSM with timeout counter and registered bus/result outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= LSU_IDLE;
            req_q       <= '0;
            cnt         <= '0;
            done_o      <= 1'b0;
            bus_err_o   <= 1'b0;
            rdata_o     <= '0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_be_o    <= '0;
            mem_wdata_o <= '0;
        end else begin
            done_o    <= 1'b0;
            bus_err_o <= 1'b0;
            case (state)
                LSU_IDLE: if (start) begin
                    state       <= LSU_REQ;
                    cnt         <= '0;
                    req_q       <= '{we: MemWr_i, op: MemOp_i, off: addr_i[1:0]};
                    mem_req_o   <= 1'b1;
                    mem_we_o    <= MemWr_i;
                    mem_addr_o  <= {addr_i[31:2], 2'b00};
                    mem_be_o    <= MemWr_i ? st_be : 4'b1111;
                    mem_wdata_o <= st_wdata;
                end
                LSU_REQ: begin
                    if (mem_gnt_i) begin
                        state     <= LSU_WAIT;
                        cnt       <= '0;
                        mem_req_o <= 1'b0;
                    end else if (timeout) begin
                        state     <= LSU_DONE;
                        mem_req_o <= 1'b0;
                        done_o    <= 1'b1;
                        bus_err_o <= 1'b1;
                        rdata_o   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                LSU_WAIT: begin
                    if (mem_rvalid_i) begin
                        state  <= LSU_DONE;
                        done_o <= 1'b1;
                        if (!req_q.we) rdata_o <= ld_data;
                    end else if (timeout) begin
                        state     <= LSU_DONE;
                        done_o    <= 1'b1;
                        bus_err_o <= 1'b1;
                        rdata_o   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= LSU_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_lsu.sv
// Bench for riscv_lsu: directed accesses with a scoreboard of expected completions.
module tb_riscv_lsu;
    import riscv_lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid_i = 1'b0, MemWr_i = 1'b0, MemtoReg_i = 1'b0;
    logic [2:0]  MemOp_i = MEMOP_NONE;
    logic [31:0] addr_i = '0, wdata_i = '0;
    logic        stall_o, done_o, misalign_o, bus_err_o;
    logic [31:0] rdata_o;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic        mem_gnt_i = 1'b0, mem_rvalid_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;

    typedef struct {
        logic [31:0] rd;
        logic        err;
    } sb_t;
    sb_t sb_q[$];

    int checks = 0;
    int errors = 0;

    riscv_lsu #(.TIMEOUT_CYCLES(64)) dut (
        .clk(clk), .rst(rst), .req_valid_i(req_valid_i), .MemWr_i(MemWr_i),
        .MemtoReg_i(MemtoReg_i), .MemOp_i(MemOp_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .stall_o(stall_o), .done_o(done_o), .rdata_o(rdata_o), .misalign_o(misalign_o),
        .bus_err_o(bus_err_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Every completion must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (!rst && done_o === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_done", done_o, 1'b0);
            end else begin
                sb_t e;
                e = sb_q.pop_front();
                chk("sb_rdata", rdata_o, e.rd);
                chk("sb_bus_err", bus_err_o, e.err);
            end
        end
    end

    task automatic drive_req(input logic wr, input logic rd, input logic [2:0] op,
                             input logic [31:0] addr, input logic [31:0] wd);
        req_valid_i = 1'b1; MemWr_i = wr; MemtoReg_i = rd;
        MemOp_i = op; addr_i = addr; wdata_i = wd;
    endtask

    task automatic clear_req();
        req_valid_i = 1'b0; MemWr_i = 1'b0; MemtoReg_i = 1'b0; MemOp_i = MEMOP_NONE;
    endtask

    // One complete access: gnt after gnt_wait REQ cycles, rvalid in the first WAIT cycle
    task automatic access(input logic wr, input logic rd, input logic [2:0] op,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] rword, input int gnt_wait, input bit rv_early,
                          input logic [3:0] exp_be, input logic [31:0] exp_wd,
                          input logic [31:0] exp_rd);
        sb_t e;
        @(negedge clk);
        drive_req(wr, rd, op, addr, wd);
        #1;
        chk("start_stall", stall_o, 1'b1);
        chk("start_misalign", misalign_o, 1'b0);
        e.rd = exp_rd; e.err = 1'b0;
        sb_q.push_back(e);
        @(negedge clk);
        clear_req();
        chk("req_valid", mem_req_o, 1'b1);
        chk("req_addr", mem_addr_o, {addr[31:2], 2'b00});
        chk("req_be", mem_be_o, exp_be);
        chk("req_we", mem_we_o, wr);
        if (wr) chk("req_wdata", mem_wdata_o, exp_wd);
        for (int i = 0; i < gnt_wait; i++) begin
            @(negedge clk);
            chk("req_hold", mem_req_o, 1'b1);
            chk("req_hold_be", mem_be_o, exp_be);
        end
        mem_gnt_i = 1'b1;
        if (rv_early) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = ~rword;
        end
        @(negedge clk);
        mem_gnt_i = 1'b0;
        chk("wait_req_low", mem_req_o, 1'b0);
        chk("wait_stall", stall_o, 1'b1);
        chk("wait_no_done", done_o, 1'b0);
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = rword;
        @(negedge clk);
        mem_rvalid_i = 1'b0;
        chk("done_pulse", done_o, 1'b1);
        chk("done_stall", stall_o, 1'b0);
        @(negedge clk);
        chk("done_one_cycle", done_o, 1'b0);
    endtask

    initial begin
        sb_t e;
        int  n;
        rst = 1'b1;
        #23;
        chk("rst_stall", stall_o, 1'b0);
        chk("rst_done", done_o, 1'b0);
        chk("rst_rdata", rdata_o, 32'h0);
        chk("rst_req", mem_req_o, 1'b0);
        chk("rst_be", mem_be_o, 4'h0);
        chk("rst_addr", mem_addr_o, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        //     wr    rd    op        addr          wdata         rword        gw er be       wd            rd
        access(1'b0, 1'b1, MEMOP_W,  32'h0000_0100, 32'h0,        32'hDEADBEEF, 0, 1, 4'b1111, 32'h0,        32'hDEADBEEF);
        access(1'b0, 1'b1, MEMOP_B,  32'h0000_0103, 32'h0,        32'h80FF0000, 0, 0, 4'b1111, 32'h0,        32'hFFFFFF80);
        access(1'b0, 1'b1, MEMOP_BU, 32'h0000_0103, 32'h0,        32'h80FF0000, 1, 0, 4'b1111, 32'h0,        32'h00000080);
        access(1'b0, 1'b1, MEMOP_HU, 32'h0000_0102, 32'h0,        32'h80FF0000, 0, 0, 4'b1111, 32'h0,        32'h000080FF);
        access(1'b0, 1'b1, MEMOP_H,  32'h0000_0102, 32'h0,        32'h80FF0000, 0, 0, 4'b1111, 32'h0,        32'hFFFF80FF);
        access(1'b0, 1'b1, MEMOP_B,  32'h0000_0101, 32'h0,        32'h0000_7F00, 0, 0, 4'b1111, 32'h0,       32'h0000007F);
        access(1'b1, 1'b0, MEMOP_B,  32'h0000_0201, 32'h12345678, 32'h0,        0, 1, 4'b0010, 32'h78787878, 32'h0000007F);
        access(1'b1, 1'b0, MEMOP_H,  32'h0000_0202, 32'h12345678, 32'h0,        3, 0, 4'b1100, 32'h56785678, 32'h0000007F);
        access(1'b1, 1'b0, MEMOP_H,  32'h0000_0200, 32'hAAAA_1234, 32'h0,       0, 0, 4'b0011, 32'h12341234, 32'h0000007F);
        access(1'b1, 1'b1, MEMOP_W,  32'h0000_0204, 32'h12345678, 32'h0,        0, 0, 4'b1111, 32'h12345678, 32'h0000007F);

        // Misaligned word and half: flagged at once, no bus traffic, no stall
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            if (k == 0) drive_req(1'b0, 1'b1, MEMOP_W, 32'h0000_0102, 32'h0);
            else        drive_req(1'b1, 1'b0, MEMOP_H, 32'h0000_0301, 32'h0);
            #1;
            chk("misalign_flag", misalign_o, 1'b1);
            chk("misalign_stall", stall_o, 1'b0);
            @(negedge clk);
            chk("misalign_no_req", mem_req_o, 1'b0);
            chk("misalign_idle", stall_o, 1'b0);
            clear_req();
            #1;
            chk("misalign_clear", misalign_o, 1'b0);
        end

        // No-op MemOp never starts an access
        @(negedge clk);
        drive_req(1'b0, 1'b1, MEMOP_NONE, 32'h0000_0100, 32'h0);
        #1;
        chk("none_stall", stall_o, 1'b0);
        chk("none_misalign", misalign_o, 1'b0);
        @(negedge clk);
        chk("none_no_req", mem_req_o, 1'b0);
        clear_req();

        // Grant withheld: abort with bus_err 64 cycles after entering REQ
        @(negedge clk);
        drive_req(1'b0, 1'b1, MEMOP_W, 32'h0000_0300, 32'h0);
        e.rd = 32'h0; e.err = 1'b1;
        sb_q.push_back(e);
        @(negedge clk);
        clear_req();
        chk("to_req", mem_req_o, 1'b1);
        n = 1;
        while (n <= 70) begin
            @(negedge clk);
            if (done_o === 1'b1) break;
            n++;
        end
        chk("to_latency", n, 64);
        mem_gnt_i = 1'b1;
        @(negedge clk);
        chk("to_idle_stall", stall_o, 1'b0);
        chk("to_idle_req", mem_req_o, 1'b0);
        chk("to_err_pulse", bus_err_o, 1'b0);
        mem_gnt_i = 1'b0;

        // Reset while in REQ: request drops immediately
        @(negedge clk);
        drive_req(1'b0, 1'b1, MEMOP_W, 32'h0000_0400, 32'h0);
        @(negedge clk);
        clear_req();
        chk("rstreq_req", mem_req_o, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("rstreq_req_drop", mem_req_o, 1'b0);
        chk("rstreq_stall", stall_o, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Reset while in WAIT: late rvalid must not complete anything
        @(negedge clk);
        drive_req(1'b0, 1'b1, MEMOP_W, 32'h0000_0400, 32'h0);
        @(negedge clk);
        clear_req();
        mem_gnt_i = 1'b1;
        @(negedge clk);
        mem_gnt_i = 1'b0;
        chk("rstwait_stall_pre", stall_o, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("rstwait_req", mem_req_o, 1'b0);
        chk("rstwait_stall", stall_o, 1'b0);
        chk("rstwait_done", done_o, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h5555_5555;
        @(negedge clk);
        mem_rvalid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("late_rvalid_done", done_o, 1'b0);
            chk("late_rvalid_stall", stall_o, 1'b0);
            @(negedge clk);
        end

        access(1'b0, 1'b1, MEMOP_W, 32'h0000_0100, 32'h0, 32'hCAFEF00D, 0, 0, 4'b1111, 32'h0, 32'hCAFEF00D);

        repeat (2) @(negedge clk);
        chk("sb_empty", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
